// File: rtl/operand_fetch_pkg.sv
// Shared widths, zero-register constant and forward-source codes for the
// operand-fetch slice of the forwarding pipeline.
package operand_fetch_pkg;

  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned ADDR_W_DEF = 5;
  localparam int unsigned ZERO_REG   = 0;

  typedef enum logic [1:0] {
    FWD_RF  = 2'd0,
    FWD_WB  = 2'd1,
    FWD_MEM = 2'd2,
    FWD_EX  = 2'd3
  } fwd_src_e;

endpackage

// File: rtl/operand_fetch_if.sv
// Decode / register-file / forwarding / execute signals seen by operand_fetch.
// The slave modport is the operand_fetch side; master is the surrounding pipeline.
interface operand_fetch_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5
);
  logic              id_valid;
  logic              id_ready;
  logic [ADDR_W-1:0] id_rs_addr;
  logic [ADDR_W-1:0] id_rt_addr;
  logic              id_uses_rs;
  logic              id_uses_rt;
  logic [ADDR_W-1:0] id_dest_addr;
  logic              id_reg_write;
  logic              id_mem_read;
  logic [ADDR_W-1:0] rf_rs_addr;
  logic [ADDR_W-1:0] rf_rt_addr;
  logic [DATA_W-1:0] rf_rs_data;
  logic [DATA_W-1:0] rf_rt_data;
  logic [DATA_W-1:0] ex_alu_result;
  logic              mem_reg_write;
  logic [ADDR_W-1:0] mem_dest_addr;
  logic [DATA_W-1:0] mem_result;
  logic              wb_reg_write;
  logic [ADDR_W-1:0] wb_dest_addr;
  logic [DATA_W-1:0] wb_result;
  logic              ex_valid;
  logic              ex_ready;
  logic [DATA_W-1:0] ex_rs_data;
  logic [DATA_W-1:0] ex_rt_data;
  logic [ADDR_W-1:0] ex_dest_addr;
  logic              ex_reg_write;
  logic              ex_mem_read;
  logic [1:0]        ex_rs_src;
  logic [1:0]        ex_rt_src;

  modport slave (
    input  id_valid, id_rs_addr, id_rt_addr, id_uses_rs, id_uses_rt,
           id_dest_addr, id_reg_write, id_mem_read,
           rf_rs_data, rf_rt_data, ex_alu_result,
           mem_reg_write, mem_dest_addr, mem_result,
           wb_reg_write, wb_dest_addr, wb_result, ex_ready,
    output id_ready, rf_rs_addr, rf_rt_addr, ex_valid, ex_rs_data, ex_rt_data,
           ex_dest_addr, ex_reg_write, ex_mem_read, ex_rs_src, ex_rt_src
  );

  modport master (
    output id_valid, id_rs_addr, id_rt_addr, id_uses_rs, id_uses_rt,
           id_dest_addr, id_reg_write, id_mem_read,
           rf_rs_data, rf_rt_data, ex_alu_result,
           mem_reg_write, mem_dest_addr, mem_result,
           wb_reg_write, wb_dest_addr, wb_result, ex_ready,
    input  id_ready, rf_rs_addr, rf_rt_addr, ex_valid, ex_rs_data, ex_rt_data,
           ex_dest_addr, ex_reg_write, ex_mem_read, ex_rs_src, ex_rt_src
  );
endinterface

// File: rtl/operand_fetch_fwd_mux.sv
// Combinational forwarding priority selector for one source operand:
// zero register, then EX, MEM, WB, and finally register-file data.
module operand_fetch_fwd_mux
  import operand_fetch_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF
) (
  input  logic [ADDR_W-1:0] srcAddr,
  input  logic              exFwdEn,
  input  logic [ADDR_W-1:0] exDest,
  input  logic [DATA_W-1:0] exResult,
  input  logic              memWe,
  input  logic [ADDR_W-1:0] memDest,
  input  logic [DATA_W-1:0] memResult,
  input  logic              wbWe,
  input  logic [ADDR_W-1:0] wbDest,
  input  logic [DATA_W-1:0] wbResult,
  input  logic [DATA_W-1:0] rfData,
  output logic [DATA_W-1:0] value,
  output fwd_src_e          code
);

  always_comb begin
    value = rfData;
    code  = FWD_RF;
    if (srcAddr == ADDR_W'(ZERO_REG)) begin
      value = '0;
      code  = FWD_RF;
    end else if (exFwdEn && exDest == srcAddr) begin
      value = exResult;
      code  = FWD_EX;
    end else if (memWe && memDest == srcAddr) begin
      value = memResult;
      code  = FWD_MEM;
    end else if (wbWe && wbDest == srcAddr) begin
      value = wbResult;
      code  = FWD_WB;
    end
  end

endmodule

// File: rtl/operand_fetch.sv
// Operand fetch stage: register-file addressing, EX/MEM/WB forwarding,
// single-bubble load-use interlock and the ID/EX pipeline register.
module operand_fetch
  import operand_fetch_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned CNT_W  = 16
) (
  input  logic             clk,
  input  logic             reset,
  operand_fetch_if.slave   bus,
  output logic [CNT_W-1:0] stall_cnt
);

  logic [DATA_W-1:0] rsVal, rtVal;
  fwd_src_e          rsCode, rtCode;
  logic              exFwdEn, loadUse, advance, accept;

  assign bus.rf_rs_addr = bus.id_rs_addr;
  assign bus.rf_rt_addr = bus.id_rt_addr;

  // A load in EX has no result yet; it is covered by the interlock instead.
  assign exFwdEn = bus.ex_valid && bus.ex_reg_write && !bus.ex_mem_read;

  operand_fetch_fwd_mux #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) uRsMux (
    .srcAddr(bus.id_rs_addr), .exFwdEn(exFwdEn),
    .exDest(bus.ex_dest_addr), .exResult(bus.ex_alu_result),
    .memWe(bus.mem_reg_write), .memDest(bus.mem_dest_addr), .memResult(bus.mem_result),
    .wbWe(bus.wb_reg_write), .wbDest(bus.wb_dest_addr), .wbResult(bus.wb_result),
    .rfData(bus.rf_rs_data), .value(rsVal), .code(rsCode)
  );

  operand_fetch_fwd_mux #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) uRtMux (
    .srcAddr(bus.id_rt_addr), .exFwdEn(exFwdEn),
    .exDest(bus.ex_dest_addr), .exResult(bus.ex_alu_result),
    .memWe(bus.mem_reg_write), .memDest(bus.mem_dest_addr), .memResult(bus.mem_result),
    .wbWe(bus.wb_reg_write), .wbDest(bus.wb_dest_addr), .wbResult(bus.wb_result),
    .rfData(bus.rf_rt_data), .value(rtVal), .code(rtCode)
  );

  always_comb begin
    loadUse = bus.id_valid && bus.ex_valid && bus.ex_mem_read &&
              (bus.ex_dest_addr != ADDR_W'(ZERO_REG)) &&
              ((bus.id_uses_rs && bus.id_rs_addr == bus.ex_dest_addr) ||
               (bus.id_uses_rt && bus.id_rt_addr == bus.ex_dest_addr));
    advance = !bus.ex_valid || bus.ex_ready;
    accept  = bus.id_valid && advance && !loadUse;
  end

  assign bus.id_ready = advance && !loadUse;

  always_ff @(posedge clk) begin
    if (reset) begin
      bus.ex_valid     <= 1'b0;
      bus.ex_rs_data   <= '0;
      bus.ex_rt_data   <= '0;
      bus.ex_dest_addr <= '0;
      bus.ex_reg_write <= 1'b0;
      bus.ex_mem_read  <= 1'b0;
      bus.ex_rs_src    <= '0;
      bus.ex_rt_src    <= '0;
      stall_cnt        <= '0;
    end else begin
      if (advance) begin
        if (accept) begin
          bus.ex_valid     <= 1'b1;
          bus.ex_rs_data   <= rsVal;
          bus.ex_rt_data   <= rtVal;
          bus.ex_dest_addr <= bus.id_dest_addr;
          bus.ex_reg_write <= bus.id_reg_write;
          bus.ex_mem_read  <= bus.id_mem_read;
          bus.ex_rs_src    <= rsCode;
          bus.ex_rt_src    <= rtCode;
        end else begin
          // Bubble: control cleared, data fields keep their last value.
          bus.ex_valid     <= 1'b0;
          bus.ex_reg_write <= 1'b0;
          bus.ex_mem_read  <= 1'b0;
        end
      end
      if (loadUse && advance && stall_cnt != '1)
        stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule

// File: doc/operand_fetch.md
Name: operand_fetch

Overview:
- Reader side of the register-file interface in the forwarding pipeline.
- Drives the register-file read addresses from the decoded instruction and resolves RAW hazards by forwarding from the EX, MEM and WB stages.
- Detects load-use hazards, inserts a single bubble and owns the ID/EX pipeline register, with valid/ready handshakes to decode and execute.

Parameters:
DATA_W, 32, operand/result width
ADDR_W, 5, register address width; address 0 is hard-wired zero
CNT_W, 16, width of the load-use stall counter

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  synchronous, active-high
id_valid  in  1  decode presents an instruction
id_ready  out  1  operand_fetch accepts the instruction this cycle
id_rs_addr  in  ADDR_W  source register rs
id_rt_addr  in  ADDR_W  source register rt
id_uses_rs  in  1  instruction reads rs
id_uses_rt  in  1  instruction reads rt
id_dest_addr  in  ADDR_W  destination register
id_reg_write  in  1  instruction writes the register file
id_mem_read  in  1  instruction is a load
rf_rs_addr  out  ADDR_W  combinational copy of id_rs_addr
rf_rt_addr  out  ADDR_W  combinational copy of id_rt_addr
rf_rs_data  in  DATA_W  register-file read data for rs
rf_rt_data  in  DATA_W  register-file read data for rt
ex_alu_result  in  DATA_W  combinational ALU result of the instruction in EX
mem_reg_write  in  1  MEM-stage instruction writes
mem_dest_addr  in  ADDR_W  MEM-stage destination
mem_result  in  DATA_W  final MEM-stage value (load data included)
wb_reg_write  in  1  WB-stage write enable (same as the register-file write enable)
wb_dest_addr  in  ADDR_W  WB destination
wb_result  in  DATA_W  WB write data
ex_valid  out  1  ID/EX register holds a valid instruction
ex_ready  in  1  execute accepts the ID/EX contents
ex_rs_data  out  DATA_W  resolved rs operand
ex_rt_data  out  DATA_W  resolved rt operand
ex_dest_addr  out  ADDR_W  registered destination
ex_reg_write  out  1  registered write enable
ex_mem_read  out  1  registered load flag
ex_rs_src  out  2  registered forward source for rs: 0 RF, 1 WB, 2 MEM, 3 EX
ex_rt_src  out  2  registered forward source for rt, same encoding
stall_cnt  out  CNT_W  load-use bubbles inserted, saturating

Behaviour:
- Reset (synchronous, active-high): all ex_* outputs are 0 and stall_cnt is 0. A reset mid-stall drops the held instruction and the bubble. Decode must re-present the instruction.
- rf_rs_addr and rf_rt_addr are pure combinational copies of the ID inputs. The register file reads combinationally, so its data is valid in the same cycle.
- Forwarding per operand (src = rs or rt), in priority order, evaluated combinationally every cycle:
  - If src == 0: the operand is 0 and the source code is 0, regardless of any match.
  - Else if ex_valid && ex_reg_write && !ex_mem_read && ex_dest_addr == src: ex_alu_result, code 3.
  - Else if mem_reg_write && mem_dest_addr == src: mem_result, code 2.
  - Else if wb_reg_write && wb_dest_addr == src: wb_result, code 1. This path is required because a register-file write lands only at the clock edge.
  - Else: rf_*_data, code 0.
- load_use = id_valid && ex_valid && ex_mem_read && ex_dest_addr != 0 && ((id_uses_rs && id_rs_addr == ex_dest_addr) || (id_uses_rt && id_rt_addr == ex_dest_addr)).
- advance = !ex_valid || ex_ready.
- id_ready = advance && !load_use.
- On each edge when advance is high:
  - If id_valid && id_ready: capture the resolved operands, source codes, dest, reg_write and mem_read; ex_valid = 1.
  - Else (bubble or empty): ex_valid = 0, ex_reg_write = 0, ex_mem_read = 0; the data fields hold their previous value.
- When advance is low, the ID/EX register holds all fields. The forwarding result is recomputed each cycle and captured only on the accepting edge.
- A load-use stall lasts exactly one cycle. On the next cycle the load is in MEM and the MEM path supplies the data.
- stall_cnt increments by 1 on each edge where load_use && advance is true, and saturates at all-ones.
- Latency: one cycle from ID handshake to ex_valid.
- Unused sources (uses_* = 0) never cause a stall but are still forwarded.

Decomposition:
- Shared package: DATA_W and ADDR_W defaults, the zero-register constant, and the forward-source codes FWD_RF=0, FWD_WB=1, FWD_MEM=2, FWD_EX=3.
- One sub-module, fwd_mux: a purely combinational priority selector returning value and code. It is instantiated twice, once for rs and once for rt.

Test Plan:
- add r3,r1,r2 in EX (ex_alu_result=0x10), next instruction reads r3 -> ex_rs_data=0x10, ex_rs_src=3, no stall.
- EX, MEM and WB all target r5 with values 0xA, 0xB, 0xC -> EX wins: 0xA, code 3. With EX not writing -> 0xB, code 2. With WB only -> 0xC, code 1.
- lw r4 in EX, next instruction uses rt=r4 -> id_ready=0 for 1 cycle and a bubble (ex_valid=0). The following cycle it takes mem_result=0x1234 with code 2, and stall_cnt=1.
- Instruction reads r0 while WB writes r0 with 0xFFFF -> operand 0, code 0. lw to r0 followed by a reader of r0 -> no stall.
- ex_ready held low for 3 cycles -> ID/EX fields stable and id_ready=0. On release, the next instruction is accepted on the first edge.
- Reset asserted during a load-use stall -> next cycle ex_valid=0, stall_cnt=0, id_ready=1. Separately, stall_cnt preloaded near max and driven with load-use stalls -> saturates at 0xFFFF.
